// File: rtl/crypt_seq_pkg.sv
// Purpose : shared types for the crypt round sequencer (permutation modes, FSM states).
// Latency : n/a (types and a pure function only).
// Backpressure : n/a.
package crypt_seq_pkg;

   // Permutation mode as driven on {k1,k0}.
   typedef enum logic [1:0] {
      PM_OUT_R = 2'b00,   // outside-right
      PM_IN_R  = 2'b01,   // inside-right
      PM_IN_L  = 2'b10,   // inside-left
      PM_OUT_L = 2'b11    // outside-left
   } perm_mode_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } seq_state_e;

   // Inverse permutation of a mode: bitwise complement swaps 00<->11 and 01<->10.
   function automatic perm_mode_e inv_mode(input perm_mode_e m);
      return perm_mode_e'(~m);
   endfunction

endpackage

// File: rtl/crypt_key_shifter.sv
// Purpose : round-key register that hands out one 2-bit key pair per round.
// Latency : pair is combinational; on load it reflects load_key directly, else the register.
// Backpressure : none; shifts only when the sequencer asks.
// Ports:
//   clk, reset_n      clock, async active-low reset (register clears to 0)
//   clear             synchronous clear (abort)
//   load, load_key    capture a new key; the first pair is consumed on the same edge
//   shift             consume the current pair
//   left              1: pairs taken MSB-first (shift left), 0: LSB-first (shift right)
//   pair              the pair for the round being issued now
module crypt_key_shifter #(
   parameter int KEY_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             load,
   input  logic             shift,
   input  logic             left,
   input  logic [KEY_W-1:0] load_key,
   output logic [1:0]       pair
);

   logic [KEY_W-1:0] key_q;
   logic [KEY_W-1:0] src;

   // The register only holds pairs not yet issued: the load edge already
   // issues pair 0, so the stored value is the key with that pair shifted out.
   assign src  = load ? load_key : key_q;
   assign pair = left ? src[KEY_W-1 -: 2] : src[1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         key_q <= '0;
      end else if (clear) begin
         key_q <= '0;
      end else if (load || shift) begin
         key_q <= left ? (src << 2) : (src >> 2);
      end
   end

endmodule

// File: rtl/crypt_round_sequencer.sv
// Purpose : issues one stage enable per round with that round's permutation mode, then a done handshake.
// Latency : start accepted at edge T -> stage_en cycles T+1..T+NUM_ROUNDS -> done_valid from T+NUM_ROUNDS+1.
// Backpressure : start_ready only in IDLE; done_valid held until done_ready; abort cancels from any state.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   start_valid/start_ready          start handshake, start_key/start_dec sampled on it
//   abort                            synchronous cancel, highest priority
//   stage_en, k0, k1, round_idx      per-round outputs (registered)
//   busy                             high in RUN or DONE
//   done_valid/done_ready            completion handshake
// Optional: define CRYPT_SEQ_DECRYPT_EN to honour start_dec (MSB-first, inverted pairs).
module crypt_round_sequencer
   import crypt_seq_pkg::*;
#(
   parameter  int NUM_ROUNDS = 8,
   localparam int KEY_W      = 2 * NUM_ROUNDS,
   localparam int CNT_W      = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [KEY_W-1:0] start_key,
   input  logic             start_dec,
   input  logic             abort,
   output logic             stage_en,
   output logic             k0,
   output logic             k1,
   output logic [CNT_W-1:0] round_idx,
   output logic             busy,
   output logic             done_valid,
   input  logic             done_ready
);

   localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS - 1);

   seq_state_e       state_q, state_d;
   perm_mode_e       mode_q, mode_d;
   logic             stage_en_d;
   logic [CNT_W-1:0] round_d;
   logic             busy_d;
   logic             done_d;
   logic             key_load;
   logic             key_shift;
   logic             key_clear;
   logic             dir_left;
   logic [1:0]       pair;
   perm_mode_e       issue_mode;

   assign start_ready = (state_q == S_IDLE);
   assign k0          = mode_q[0];
   assign k1          = mode_q[1];

`ifdef CRYPT_SEQ_DECRYPT_EN
   logic dec_q;

   // On the start edge the direction comes straight from the request; after
   // that it comes from the latched copy.
   assign dir_left = (state_q == S_IDLE) ? start_dec : dec_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dec_q <= 1'b0;
      end else if (abort) begin
         dec_q <= 1'b0;
      end else if (start_valid && start_ready) begin
         dec_q <= start_dec;
      end
   end
`else
   logic unused_start_dec;
   assign unused_start_dec = start_dec;
   assign dir_left         = 1'b0;
`endif

   assign issue_mode = dir_left ? inv_mode(perm_mode_e'(pair)) : perm_mode_e'(pair);

   crypt_key_shifter #(
      .KEY_W(KEY_W)
   ) u_key_shifter (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (key_clear),
      .load     (key_load),
      .shift    (key_shift),
      .left     (dir_left),
      .load_key (start_key),
      .pair     (pair)
   );

   always_comb begin
      state_d    = state_q;
      mode_d     = PM_OUT_R;
      stage_en_d = 1'b0;
      round_d    = round_idx;
      busy_d     = busy;
      done_d     = done_valid;
      key_load   = 1'b0;
      key_shift  = 1'b0;
      key_clear  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_valid) begin
               state_d    = S_RUN;
               stage_en_d = 1'b1;
               mode_d     = issue_mode;
               round_d    = '0;
               busy_d     = 1'b1;
               key_load   = 1'b1;
            end
         end
         S_RUN: begin
            if (round_idx == LAST_ROUND) begin
               state_d = S_DONE;
               done_d  = 1'b1;
            end else begin
               stage_en_d = 1'b1;
               mode_d     = issue_mode;
               round_d    = round_idx + CNT_W'(1);
               key_shift  = 1'b1;
            end
         end
         S_DONE: begin
            if (done_ready) begin
               state_d = S_IDLE;
               done_d  = 1'b0;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase

      // Abort wins over start and done_ready and leaves everything as after reset.
      if (abort) begin
         state_d    = S_IDLE;
         mode_d     = PM_OUT_R;
         stage_en_d = 1'b0;
         round_d    = '0;
         busy_d     = 1'b0;
         done_d     = 1'b0;
         key_load   = 1'b0;
         key_shift  = 1'b0;
         key_clear  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         mode_q     <= PM_OUT_R;
         stage_en   <= 1'b0;
         round_idx  <= '0;
         busy       <= 1'b0;
         done_valid <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         stage_en   <= stage_en_d;
         round_idx  <= round_d;
         busy       <= busy_d;
         done_valid <= done_d;
      end
   end

endmodule

// File: tb/tb_crypt_round_sequencer.sv
// Purpose : self-checking bench for crypt_round_sequencer with NUM_ROUNDS=4.
// Latency : n/a.
// Backpressure : exercises done_ready stalls, abort and async reset.
module tb_crypt_round_sequencer;

   localparam int NR = 4;
`ifdef CRYPT_SEQ_DECRYPT_EN
   localparam bit DEC_EN = 1'b1;
`else
   localparam bit DEC_EN = 1'b0;
`endif

   typedef struct {
      logic       k0;
      logic       k1;
      logic [1:0] idx;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start_valid = 1'b0;
   logic [7:0] start_key = 8'h00;
   logic       start_dec = 1'b0;
   logic       abort = 1'b0;
   logic       done_ready = 1'b0;
   logic       start_ready;
   logic       stage_en;
   logic       k0;
   logic       k1;
   logic [1:0] round_idx;
   logic       busy;
   logic       done_valid;

   exp_t exp_q[$];
   int   pending = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   prev_done = 1'b0;

   crypt_round_sequencer #(
      .NUM_ROUNDS(NR)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .start_key   (start_key),
      .start_dec   (start_dec),
      .abort       (abort),
      .stage_en    (stage_en),
      .k0          (k0),
      .k1          (k1),
      .round_idx   (round_idx),
      .busy        (busy),
      .done_valid  (done_valid),
      .done_ready  (done_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: round r uses key pair r (LSB-first); decrypt uses pair NR-1-r, complemented.
   function automatic void push_model(input logic [7:0] key, input logic dec);
      exp_t       e;
      logic [1:0] p;
      for (int r = 0; r < NR; r++) begin
         if (dec) p = ~key[2*(NR-1-r) +: 2];
         else     p = key[2*r +: 2];
         e.k0  = p[0];
         e.k1  = p[1];
         e.idx = 2'(r);
         exp_q.push_back(e);
      end
      pending++;
   endfunction

   task automatic check_cleared(input string tag);
      check({tag, "_stage_en"}, stage_en, 0);
      check({tag, "_k0"}, k0, 0);
      check({tag, "_k1"}, k1, 0);
      check({tag, "_round_idx"}, round_idx, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done_valid"}, done_valid, 0);
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic issue_start(input logic [7:0] key, input logic dec);
      check("start_ready_idle", start_ready, 1);
      start_valid = 1'b1;
      start_key   = key;
      start_dec   = dec;
      push_model(key, dec & DEC_EN);
      @(posedge clk);
      #1 start_valid = 1'b0;
   endtask

   task automatic finish_block(input int stall);
      int lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done_valid) begin
            lat = i;
            break;
         end
      end
      check("done_latency", lat, NR + 1);
      if (lat == 0) begin
         exp_q.delete();
         pending = 0;
         @(posedge clk); #1 abort = 1'b1;
         @(posedge clk); #1 abort = 1'b0;
         return;
      end
      check("rounds_issued_before_done", exp_q.size(), 0);
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         #1 start_valid = (s == 0);
         @(negedge clk);
         check("done_held", done_valid, 1);
         check("start_ready_in_done", start_ready, 0);
         check("busy_in_done", busy, 1);
      end
      @(posedge clk);
      #1 start_valid = 1'b0;
      done_ready = 1'b1;
      @(posedge clk);
      #1 done_ready = 1'b0;
      check("done_dropped", done_valid, 0);
      check("start_ready_after_done", start_ready, 1);
      check("busy_after_done", busy, 0);
   endtask

   task automatic run_block(input logic [7:0] key, input logic dec, input int stall);
      issue_start(key, dec);
      finish_block(stall);
   endtask

   // Monitor: pops one expected round per stage_en cycle; counts done pulses.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (stage_en) begin
            if (exp_q.size() == 0) begin
               check("unexpected_stage_en", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("k0", k0, e.k0);
               check("k1", k1, e.k1);
               check("round_idx", round_idx, e.idx);
            end
         end
         if (done_valid && !prev_done) begin
            check("done_expected", pending > 0, 1);
            if (pending > 0) pending--;
         end
         prev_done = done_valid;
      end
   end

   initial begin
      logic [7:0] key;
      #1;
      check_cleared("reset");
      check("reset_start_ready", start_ready, 1);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed blocks, including the decrypt-request cases.
      run_block(8'hE4, 1'b0, 3);
      run_block(8'h00, 1'b1, 0);
      run_block(8'h1B, 1'b1, 1);
      run_block(8'h1B, 1'b0, 0);

      // Abort during round 2; a new start goes in on the very next cycle.
      issue_start(8'h5A, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      exp_q.delete();
      pending--;
      check_cleared("abort");
      check("abort_start_ready", start_ready, 1);
      run_block(8'hC3, 1'b0, 0);

      // Abort beats a simultaneous start.
      start_valid = 1'b1;
      abort       = 1'b1;
      @(posedge clk);
      #1 start_valid = 1'b0;
      abort = 1'b0;
      check("abort_over_start_busy", busy, 0);
      check("abort_over_start_ready", start_ready, 1);

      // Async reset in round 1: outputs clear with no clock edge.
      issue_start(8'h96, 1'b0);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      check_cleared("async_reset");
      exp_q.delete();
      pending--;
      @(posedge clk);
      #1 reset_n = 1'b1;
      #1 check("start_ready_after_reset", start_ready, 1);
      @(posedge clk);
      #1;

      // Randomised blocks.
      for (int n = 0; n < 12; n++) begin
         key = 8'($urandom);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         run_block(key, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end

      repeat (3) @(posedge clk);
      #1;
      check("leftover_rounds", exp_q.size(), 0);
      check("leftover_done", pending, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
